// File: rtl/tof_trig_pkg.sv
// Shared definitions for the time-of-flight trigger sequencer:
// state encoding, Q16.16 one-cycle step, default sample width and
// a saturating counter helper.
package tof_trig_pkg;

    localparam int ADC_DATA_WIDTH_DEF = 16;

    // One cycle expressed in Q16.16
    localparam logic signed [31:0] Q16_ONE = 32'sh0001_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMING = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DELAY  = 3'd4,
        ST_FIRE   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        sat_inc32 = (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/trig_window_cmp.sv
// Per-channel sample-pair sum register and signed window compare.
// The sum carries one extra bit so two full-scale samples never overflow;
// the levels are doubled to match the scale of a two-sample sum.
module trig_window_cmp #(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [2*DW-1:0] data,
    input  logic [2*DW-1:0] level,
    output logic            hit
);

    logic signed [DW:0] sum_r;
    logic signed [DW:0] sum_next_s;
    logic signed [DW:0] upper_s;
    logic signed [DW:0] lower_s;

    // Sign-extended sum of the two samples and the doubled window edges
    always_comb begin
        sum_next_s = $signed({data[DW-1], data[DW-1:0]})
                   + $signed({data[2*DW-1], data[2*DW-1:DW]});
        upper_s    = $signed({level[2*DW-1:DW], 1'b0});
        lower_s    = $signed({level[DW-1:0], 1'b0});
    end

    // Sum register, loaded only while the channel is enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r <= {(DW+1){1'b0}};
        end else if (en) begin
            sum_r <= sum_next_s;
        end
    end

    assign hit = (sum_r > upper_s) || (sum_r < lower_s);

endmodule

// File: rtl/tof_trigger_seq.sv
// Multi-stage time-of-flight trigger sequencer. Each stage waits for a
// window hit on its selected channel; the time between the stage-0 and
// final-stage hits scales a Q16.16 delay after which one trigger pulse
// is emitted.
// Optional build macro TOF_TRIG_TIMEOUT_EN adds the timeout_cycles port
// and aborts a post-stage-0 WAIT that lasts too long.
module tof_trigger_seq
    import tof_trig_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int NUM_STAGES     = 3,
    parameter int ADC_DATA_WIDTH = ADC_DATA_WIDTH_DEF,
    parameter int CH_W           = $clog2(NUM_CH)
) (
    input  logic                       rxclk,
    input  logic                       rst,
    input  logic [NUM_CH*32-1:0]       adc_data,
    input  logic [NUM_CH-1:0]          adc_enable,
    input  logic                       trig_enable,
    input  logic [NUM_CH*32-1:0]       trig_level,
    input  logic [NUM_STAGES*CH_W-1:0] stage_ch,
    input  logic [31:0]                init_delay,
    input  logic [31:0]                hold_cycles,
    input  logic signed [31:0]         param_mul,
    input  logic signed [31:0]         param_off,
    input  logic                       rearm,
`ifdef TOF_TRIG_TIMEOUT_EN
    input  logic [31:0]                timeout_cycles,
`endif
    output logic                       trig_out,
    output logic [31:0]                pulse_tof,
    output logic [7:0]                 detect_pls,
    output logic [15:0]                event_cnt
);

    localparam int IDX_W = $clog2(NUM_STAGES);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    state_t             state_r;
    logic [31:0]        hold_cnt_r;
    logic [IDX_W-1:0]   idx_r;
    logic signed [31:0] acc_r;
    logic [31:0]        cyc_r;
    logic signed [31:0] dly_r;
`ifdef TOF_TRIG_TIMEOUT_EN
    logic [31:0]        wait_cnt_r;
`endif

    logic [NUM_CH-1:0]  hits_s;
    logic [CH_W-1:0]    sel_s;
    logic               hit_sel_s;
    logic signed [31:0] acc_step_s;
    logic [31:0]        cyc_step_s;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        trig_window_cmp #(
            .DW (ADC_DATA_WIDTH)
        ) u_cmp (
            .clk   (rxclk),
            .rst   (rst),
            .en    (adc_enable[k]),
            .data  (adc_data[32*k +: 2*ADC_DATA_WIDTH]),
            .level (trig_level[32*k +: 2*ADC_DATA_WIDTH]),
            .hit   (hits_s[k])
        );
    end

    // Channel watched by the current stage; selectors past NUM_CH match nothing
    always_comb begin
        sel_s     = {CH_W{1'b0}};
        hit_sel_s = 1'b0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            sel_s = (idx_r == IDX_W'(s)) ? stage_ch[s*CH_W +: CH_W] : sel_s;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            hit_sel_s = (sel_s == CH_W'(k)) ? hits_s[k] : hit_sel_s;
        end
        acc_step_s = acc_r + param_mul;
        cyc_step_s = sat_inc32(cyc_r);
    end

    // Sequencer: every HOLD and post-stage-0 WAIT cycle, the final WAIT
    // cycle included, adds one step, so pulse_tof equals the cycle distance
    // between the stage-0 and final-stage detections.
    always_ff @(posedge rxclk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= 32'd0;
            idx_r      <= IDX_ZERO;
            acc_r      <= 32'sd0;
            cyc_r      <= 32'd0;
            dly_r      <= 32'sd0;
            trig_out   <= 1'b0;
            pulse_tof  <= 32'hFFFF_FFFF;
            detect_pls <= 8'h00;
            event_cnt  <= 16'h0000;
`ifdef TOF_TRIG_TIMEOUT_EN
            wait_cnt_r <= 32'd0;
`endif
        end else if (!trig_enable) begin
            state_r       <= ST_IDLE;
            trig_out      <= 1'b0;
            detect_pls[0] <= 1'b0;
        end else begin
            trig_out <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_ARMING;
                    hold_cnt_r <= init_delay;
                    idx_r      <= IDX_ZERO;
                    detect_pls <= 8'h01;
                end
                ST_ARMING: begin
                    if (hold_cnt_r == 32'd0) begin
                        state_r       <= ST_WAIT;
                        detect_pls[0] <= 1'b0;
`ifdef TOF_TRIG_TIMEOUT_EN
                        wait_cnt_r    <= 32'd0;
`endif
                    end else begin
                        hold_cnt_r <= hold_cnt_r - 32'd1;
                    end
                end
                ST_WAIT: begin
                    if (idx_r != IDX_ZERO) begin
                        acc_r <= acc_step_s;
                        cyc_r <= cyc_step_s;
                    end
                    if (hit_sel_s) begin
                        if (idx_r == IDX_ZERO) begin
                            acc_r         <= 32'sd0;
                            cyc_r         <= 32'd0;
                            detect_pls[1] <= 1'b1;
                            state_r       <= ST_HOLD;
                            hold_cnt_r    <= hold_cycles;
                        end else if (idx_r == LAST_IDX) begin
                            detect_pls[NUM_STAGES] <= 1'b1;
                            pulse_tof  <= cyc_step_s;
                            acc_r      <= acc_step_s + param_off;
                            dly_r      <= 32'sd0;
                            state_r    <= ST_DELAY;
                        end else begin
                            detect_pls <= detect_pls | (8'h02 << idx_r);
                            state_r    <= ST_HOLD;
                            hold_cnt_r <= hold_cycles;
                        end
                    end
`ifdef TOF_TRIG_TIMEOUT_EN
                    else if ((idx_r != IDX_ZERO) && (wait_cnt_r >= timeout_cycles)) begin
                        state_r    <= ST_ARMING;
                        hold_cnt_r <= init_delay;
                        idx_r      <= IDX_ZERO;
                        detect_pls <= 8'h01;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 32'd1;
                    end
`else
                    else begin
                        state_r <= ST_WAIT;
                    end
`endif
                end
                ST_HOLD: begin
                    acc_r <= acc_step_s;
                    cyc_r <= cyc_step_s;
                    if (hold_cnt_r == 32'd0) begin
                        state_r    <= ST_WAIT;
                        idx_r      <= idx_r + IDX_W'(1);
`ifdef TOF_TRIG_TIMEOUT_EN
                        wait_cnt_r <= 32'd0;
`endif
                    end else begin
                        hold_cnt_r <= hold_cnt_r - 32'd1;
                    end
                end
                ST_DELAY: begin
                    if (dly_r >= acc_r) begin
                        state_r       <= ST_FIRE;
                        trig_out      <= 1'b1;
                        detect_pls[7] <= 1'b1;
                        event_cnt     <= event_cnt + 16'd1;
                    end else begin
                        dly_r <= dly_r + Q16_ONE;
                    end
                end
                ST_FIRE: begin
                    if (rearm) begin
                        state_r    <= ST_ARMING;
                        hold_cnt_r <= init_delay;
                        idx_r      <= IDX_ZERO;
                        detect_pls <= 8'h01;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tof_trigger_seq.sv
// Directed self-checking bench for tof_trigger_seq (default build).
// Expected trigger results are queued when a sequence is driven and
// compared when the trigger pulse appears.
module tb_tof_trigger_seq;

    localparam int NUM_CH     = 4;
    localparam int NUM_STAGES = 3;

    logic                 rxclk = 1'b0;
    logic                 rst;
    logic [NUM_CH*32-1:0] adc_data;
    logic [NUM_CH-1:0]    adc_enable;
    logic                 trig_enable;
    logic [NUM_CH*32-1:0] trig_level;
    logic [5:0]           stage_ch;
    logic [31:0]          init_delay;
    logic [31:0]          hold_cycles;
    logic [31:0]          param_mul;
    logic [31:0]          param_off;
    logic                 rearm;
`ifdef TOF_TRIG_TIMEOUT_EN
    logic [31:0]          timeout_cycles;
`endif
    logic                 trig_out;
    logic [31:0]          pulse_tof;
    logic [7:0]           detect_pls;
    logic [15:0]          event_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          fire;
        logic [31:0] tof;
        logic [15:0] evt;
    } exp_t;

    exp_t sb[$];
    logic hq[$];

    tof_trigger_seq #(
        .NUM_CH     (NUM_CH),
        .NUM_STAGES (NUM_STAGES)
    ) dut (
        .rxclk          (rxclk),
        .rst            (rst),
        .adc_data       (adc_data),
        .adc_enable     (adc_enable),
        .trig_enable    (trig_enable),
        .trig_level     (trig_level),
        .stage_ch       (stage_ch),
        .init_delay     (init_delay),
        .hold_cycles    (hold_cycles),
        .param_mul      (param_mul),
        .param_off      (param_off),
        .rearm          (rearm),
`ifdef TOF_TRIG_TIMEOUT_EN
        .timeout_cycles (timeout_cycles),
`endif
        .trig_out       (trig_out),
        .pulse_tof      (pulse_tof),
        .detect_pls     (detect_pls),
        .event_cnt      (event_cnt)
    );

    always #4 rxclk = ~rxclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge rxclk);
            #1;
            cyc++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [15:0] lo, input logic [15:0] hi);
        adc_data[32*k +: 32] = {hi, lo};
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_trig"},  32'(trig_out),   32'd0);
        check({tag, "_flags"}, 32'(detect_pls), 32'd0);
        check({tag, "_evt"},   32'(event_cnt),  32'd0);
        check({tag, "_tof"},   pulse_tof,       32'hFFFF_FFFF);
    endtask

    task automatic arm_to_wait();
        trig_enable = 1'b1;
        tick(1);
        check("arm_flag", 32'(detect_pls), 32'h01);
        tick(int'(init_delay));
        check("arm_hold", 32'(detect_pls), 32'h01);
        tick(1);
        check("wait_entry", 32'(detect_pls), 32'h00);
    endtask

    // Hit lands on the second tick: one cycle to register the sum, one to detect
    task automatic hit_ch(input int k);
        set_ch(k, 16'd150, 16'd150);
        tick(1);
        set_ch(k, 16'd0, 16'd0);
        tick(1);
    endtask

    task automatic wait_fire();
        exp_t e;
        int   i;
        i = 0;
        while (trig_out !== 1'b1 && i < 1000) begin
            tick(1);
            i++;
        end
        e = sb.pop_front();
        check("fire_seen",  32'(trig_out),   32'd1);
        check("fire_cycle", 32'(cyc),        32'(e.fire));
        check("fire_tof",   pulse_tof,       e.tof);
        check("event_cnt",  32'(event_cnt),  32'(e.evt));
        check("fire_flags", 32'(detect_pls), 32'h8E);
    endtask

    task automatic run_seq(input int g1, input int g2, input logic [15:0] exp_evt);
        int                 tof;
        int                 k;
        logic signed [31:0] acc;
        hit_ch(0);
        check("stage0_flags", 32'(detect_pls), 32'h02);
        tick(g1);
        hit_ch(1);
        check("stage1_flags", 32'(detect_pls), 32'h06);
        tick(g2);
        hit_ch(2);
        check("final_flags", 32'(detect_pls), 32'h0E);
        tof = g1 + g2 + 4;
        check("pulse_tof", pulse_tof, 32'(tof));
        acc = $signed(32'(tof) * param_mul + param_off);
        k = (acc <= 32'sd0) ? 0 : int'((longint'(acc) + 64'sd65535) / 64'sd65536);
        sb.push_back('{cyc + 1 + k, 32'(tof), exp_evt});
        wait_fire();
    endtask

    task automatic win_probe(input logic [15:0] lo, input logic [15:0] hi, input logic exp_hit);
        trig_enable = 1'b0;
        tick(1);
        arm_to_wait();
        hq.push_back(exp_hit);
        set_ch(0, lo, hi);
        tick(1);
        check("win_latency", 32'(detect_pls), 32'h00);
        tick(1);
        set_ch(0, 16'd0, 16'd0);
        check("window_hit", 32'(detect_pls[1]), 32'(hq.pop_front()));
    endtask

    initial begin
        logic seen;
        rst         = 1'b1;
        adc_data    = '0;
        adc_enable  = 4'hF;
        trig_enable = 1'b0;
        for (int k = 0; k < NUM_CH; k++) trig_level[32*k +: 32] = {16'h0064, 16'hFF9C};
        stage_ch    = {2'd2, 2'd1, 2'd0};
        init_delay  = 32'd0;
        hold_cycles = 32'd2;
        param_mul   = 32'h0001_0000;
        param_off   = 32'h0000_0000;
        rearm       = 1'b0;
`ifdef TOF_TRIG_TIMEOUT_EN
        timeout_cycles = 32'hFFFF_FFFF;
`endif
        tick(2);
        check_reset("rst");
        rst = 1'b0;
        tick(1);
        check_reset("idle");

        // Window edges: levels +100/-100 become +200/-200 on the sum
        win_probe(16'd100,  16'd100,  1'b0);
        win_probe(16'd101,  16'd100,  1'b1);
        win_probe(16'hFF9B, 16'hFF9C, 1'b1);
        win_probe(16'hFF9C, 16'hFF9C, 1'b0);
        win_probe(16'h7FFF, 16'h7FFF, 1'b1);
        win_probe(16'h8000, 16'h8000, 1'b1);

        // Single shot, unit multiplier: pulse_tof 20, fire 21 cycles after final hit
        trig_enable = 1'b0;
        tick(1);
        init_delay = 32'd4;
        arm_to_wait();
        run_seq(8, 8, 16'd1);
        tick(5);
        check("done_quiet", 32'(trig_out),   32'd0);
        check("done_evt",   32'(event_cnt),  32'd1);
        check("done_flags", 32'(detect_pls), 32'h8E);

        // Negative accumulator fires right after one DELAY cycle
        trig_enable = 1'b0;
        tick(1);
        check("tof_kept_idle", pulse_tof, 32'd20);
        param_off = 32'h8000_0000;
        arm_to_wait();
        run_seq(2, 2, 16'd2);

        rst = 1'b1;
        trig_enable = 1'b0;
        tick(1);
        rst = 1'b0;
        check_reset("rst2");

        // Continuous mode, half-cycle multiplier, minimum hold
        rearm       = 1'b1;
        hold_cycles = 32'd0;
        init_delay  = 32'd1;
        param_mul   = 32'h0000_8000;
        param_off   = 32'h0000_0000;
        arm_to_wait();
        run_seq(0, 0, 16'd1);
        arm_to_wait();
        run_seq(3, 5, 16'd2);
        arm_to_wait();
        run_seq(7, 1, 16'd3);

        // trig_enable dropped during HOLD
        trig_enable = 1'b0;
        tick(1);
        rearm       = 1'b0;
        hold_cycles = 32'd2;
        arm_to_wait();
        hit_ch(0);
        tick(1);
        trig_enable = 1'b0;
        tick(1);
        check("hold_drop_trig", 32'(trig_out),  32'd0);
        check("hold_drop_tof",  pulse_tof,      32'd12);
        check("hold_drop_evt",  32'(event_cnt), 32'd3);
        trig_enable = 1'b1;
        tick(1);
        check("idle_rearm", 32'(detect_pls), 32'h01);

        // Reset while in DELAY aborts without a pulse
        trig_enable = 1'b0;
        tick(1);
        param_mul = 32'h0001_0000;
        param_off = 32'h0010_0000;
        arm_to_wait();
        hit_ch(0);
        tick(2);
        hit_ch(1);
        tick(2);
        hit_ch(2);
        check("delay_tof", pulse_tof, 32'd8);
        tick(5);
        check("delay_quiet", 32'(trig_out), 32'd0);
        rst = 1'b1;
        trig_enable = 1'b0;
        tick(1);
        rst = 1'b0;
        check_reset("rst_delay");
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            seen = seen | trig_out;
        end
        check("no_pulse_after_abort", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
